// File: rtl/mem_port_arbiter_if.sv
// Shared memory-port bundle: two requester channels plus the memory-side strobe/address/data.
// The arbiter takes the slave view; requesters and the memory model together take the master view.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          req0;
    logic          req1;
    logic          we0;
    logic          we1;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata0;
    logic [DW-1:0] wdata1;
    logic          lock0;
    logic          lock1;
    logic          gnt0;
    logic          gnt1;
    logic          rvalid0;
    logic          rvalid1;
    logic [DW-1:0] rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, lock0, lock1, mem_rdata,
        output gnt0, gnt1, rvalid0, rvalid1, rdata, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, lock0, lock1, mem_rdata,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter with burst lock sharing one 1-cycle-latency memory between core (0) and loader (1).
// Grant is combinational (0 cycles); read data returns 1 cycle after grant; a denied port simply stalls.
module mem_port_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic                clk_i,
    input  logic                reset_i,
    mem_port_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_P0   = 2'd1,
        OWN_P1   = 2'd2
    } owner_e;

    owner_e        owner_q, owner_d;
    logic          last_q, last_d;
    logic          rd_pend_q, rd_pend_d;
    logic          rd_port_q, rd_port_d;

    logic          gnt0, gnt1;
    logic          we_sel;
    logic [AW-1:0] addr_sel;
    logic [DW-1:0] wdata_sel;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            owner_q   <= OWN_NONE;
            last_q    <= 1'b1;
            rd_pend_q <= 1'b0;
            rd_port_q <= 1'b0;
        end else begin
            owner_q   <= owner_d;
            last_q    <= last_d;
            rd_pend_q <= rd_pend_d;
            rd_port_q <= rd_port_d;
        end
    end

    // Ownership changes only on a granted beat; an idle owner keeps the port.
    always_comb begin
        owner_d   = owner_q;
        last_d    = last_q;
        rd_pend_d = 1'b0;
        rd_port_d = rd_port_q;
        if (gnt0) begin
            last_d    = 1'b0;
            owner_d   = bus.lock0 ? OWN_P0 : OWN_NONE;
            rd_pend_d = !bus.we0;
            rd_port_d = 1'b0;
        end else if (gnt1) begin
            last_d    = 1'b1;
            owner_d   = bus.lock1 ? OWN_P1 : OWN_NONE;
            rd_pend_d = !bus.we1;
            rd_port_d = 1'b1;
        end
    end

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset_i) begin
            case (owner_q)
                OWN_P0:  gnt0 = bus.req0;
                OWN_P1:  gnt1 = bus.req1;
                default: begin
                    if (bus.req0 && bus.req1) begin
                        gnt0 = last_q;
                        gnt1 = !last_q;
                    end else begin
                        gnt0 = bus.req0;
                        gnt1 = bus.req1;
                    end
                end
            endcase
        end

        we_sel    = 1'b0;
        addr_sel  = '0;
        wdata_sel = '0;
        if (gnt0) begin
            we_sel    = bus.we0;
            addr_sel  = bus.addr0;
            wdata_sel = bus.wdata0;
        end else if (gnt1) begin
            we_sel    = bus.we1;
            addr_sel  = bus.addr1;
            wdata_sel = bus.wdata1;
        end
    end

    assign bus.gnt0      = gnt0;
    assign bus.gnt1      = gnt1;
    assign bus.mem_en    = gnt0 | gnt1;
    assign bus.mem_we    = we_sel;
    assign bus.mem_addr  = addr_sel;
    assign bus.mem_wdata = wdata_sel;
    // Masked during reset so an in-flight read never surfaces.
    assign bus.rvalid0   = rd_pend_q & !rd_port_q & !reset_i;
    assign bus.rvalid1   = rd_pend_q &  rd_port_q & !reset_i;
    assign bus.rdata     = bus.mem_rdata;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter sharing the single memory port between the multicycle RISC-V core (port 0) and the debug/program loader (port 1). Sits between the requesters and the unified instruction/data memory, which has a synchronous read with 1-cycle latency. It grants one request per cycle, routes the write strobe/address/data to memory, and steers the returned read data back to the port that issued the read. The core uses `gnt0` as its clock enable, so a denied core cycle is a clean stall.

## Interface
- `AW`, default 32, address width.
- `DW`, default 32, data width.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req0`, `req1`  in  1  request valid from port 0 / port 1.
- `we0`, `we1`  in  1  1 = write, 0 = read.
- `addr0`, `addr1`  in  AW  byte address.
- `wdata0`, `wdata1`  in  DW  write data.
- `lock0`, `lock1`  in  1  keep ownership after this granted beat (burst).
- `gnt0`, `gnt1`  out  1  request accepted this cycle (combinational).
- `rvalid0`, `rvalid1`  out  1  read data valid for that port (registered).
- `rdata`  out  DW  read data, shared by both ports; qualified by `rvalidN`.
- `mem_en`  out  1  memory access this cycle.
- `mem_we`  out  1  memory write strobe.
- `mem_addr`  out  AW  memory address.
- `mem_wdata`  out  DW  memory write data.
- `mem_rdata`  in  DW  memory read data, valid the cycle after a read access.

## Operation
- State registers:
  - `last` (1 bit): port granted most recently.
  - `owner` (2 bits): NONE, P0 or P1.
  - `rd_pend` (1 bit): a read is in flight.
  - `rd_port` (1 bit): port that issued the in-flight read.
- Grant selection, evaluated combinationally each cycle:
  - When `owner` = P0 or P1, only the owning port can be granted; the other port gets `gnt` = 0 even if requesting.
  - When `owner` = NONE and exactly one port requests, grant it.
  - When `owner` = NONE and both ports request, round-robin: grant the port != `last`.
  - No request: `gnt0` = `gnt1` = 0 and `mem_en` = 0.
- Memory drive:
  - `mem_en` = `gnt0` | `gnt1`.
  - `mem_we`, `mem_addr` and `mem_wdata` are taken from the granted port.
  - With no grant, they are 0.
- On any grant to port N:
  - `last` <= N.
  - If `lockN` = 1, `owner` <= PN.
  - If `lockN` = 0, `owner` <= NONE.
- Lock ownership held with no request:
  - When `owner` = PN and `reqN` = 0 in a cycle, ownership is kept.
  - Port N releases ownership only by a granted beat with `lockN` = 0.
- Read return:
  - A granted read (`we` = 0) sets `rd_pend` <= 1 and `rd_port` <= N; otherwise `rd_pend` <= 0.
  - `rvalidN` = `rd_pend` & (`rd_port` == N).
  - `rdata` = `mem_rdata` directly (no extra register).
- Writes: complete in the grant cycle; no response.
- Back-to-back: a new grant is allowed in the same cycle a previous read returns. Memory is pipelined, so reads are sustained at 1 per cycle.

## Timing
- Grant latency: 0 cycles (`gnt` in the same cycle as `req` when uncontested).
- Read data latency: exactly 1 cycle after the grant cycle.
- Requesters must hold `req`, `we`, `addr` and `wdata` stable until `gnt` is sampled high.
- Reset values:
  - `last` = 1, so port 0 wins the first tie.
  - `owner` = NONE; `rd_pend` = 0.
  - All outputs `gnt0/1`, `rvalid0/1`, `mem_en` and `mem_we` are 0 in any cycle where `reset` = 1. Grants are forced low while reset is asserted.
- Reset mid-burst or with a read in flight:
  - Ownership is dropped.
  - `rd_pend` clears, so the pending `rvalid` is never issued.
- Starvation bound:
  - Without locks, a continuously requesting port waits at most 1 cycle.
  - With locks, the wait is unbounded by design; the loader only locks while the core is held in reset.
- Simultaneous events:
  - The lock is taken on the same edge as the grant that carries it.
  - A lock asserted by a non-granted port is ignored.

## Test plan
- Reset, then `req0`=1 read addr 0x10, `mem_rdata`=0xDEADBEEF next cycle -> `gnt0`=1 in cycle 0, `mem_addr`=0x10, `mem_we`=0; `rvalid0`=1 and `rdata`=0xDEADBEEF in cycle 1; `rvalid1`=0.
- Both ports request reads continuously for 6 cycles -> grants alternate 0,1,0,1,0,1; each `rvalid` lands 1 cycle after that port's grant on the correct port.
- Port 1 writes 4 beats to 0x100..0x10C with `lock1`=1 on beats 0-2 and 0 on beat 3, port 0 requesting throughout -> `gnt0`=0 for those 4 cycles; `mem_we`=1 with the correct addr/data; port 0 is granted in cycle 4.
- Port 1 locks, then deasserts `req1` for 2 cycles while `req0`=1 -> no grants in those cycles; port 0 is granted only after port 1's unlocked beat.
- Read granted to port 0, `reset` asserted the next cycle -> `rvalid0`=0 and all grants 0 during reset; port 0 wins the first tie after reset.
- A write by port 0 followed by a read by port 1 in consecutive cycles -> `mem_en`=1 both cycles; `rvalid1` follows the read; no `rvalid` for the write.
